// File: rtl/mcu_subsys_pkg.sv
// Shared types and constants for the MCU subsystem copy engine.
package mcu_subsys_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        ABORT,
        DONE
    } dma_state_t;

    localparam logic [3:0]  WSTRB_RD   = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mcu_subsys_bus_watchdog.sv
// Stall watchdog: flags a bus request that has waited TIMEOUT cycles for ready.
// Implemented as a down-counter that reloads whenever the bus is not stalled.
// TIMEOUT = 0 disables the watchdog entirely.
module mcu_subsys_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic ready,
    output logic expired
);

    localparam int CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RELOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] remain_q;
    logic          stall;

    assign stall = valid && !ready;

    // Count down once per stalled cycle; any non-stalled cycle reloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= CW'(RELOAD);
        end else if (!stall) begin
            remain_q <= CW'(RELOAD);
        end else if (remain_q != '0) begin
            remain_q <= remain_q - CW'(1);
        end
    end

    // Terminal count: this cycle is the TIMEOUT-th consecutive stall.
    assign expired = (TIMEOUT != 0) && stall && (remain_q == '0);

endmodule

// File: rtl/mcu_subsys_dma_copy.sv
// Word copy engine on the native memory interface: one read then one write per word.
//
// state | meaning
// IDLE  | waiting for start; bus idle
// RD    | read request at src, captures rdata on completion
// WR    | write request at dst with last read word
// ABORT | watchdog fired; bus dropped, err set
// DONE  | one-cycle done pulse, then back to IDLE
module mcu_subsys_dma_copy
    import mcu_subsys_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    dma_state_t       state_q, state_d;
    logic [31:0]      src_q, dst_q, wdata_q;
    logic [LEN_W-1:0] cnt_q;
    logic             err_q;
    logic             accept;
    logic             expired;

    mcu_subsys_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .valid   (mem_valid),
        .ready   (mem_ready),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus outputs; request fields come straight from held registers
    // so they stay stable for the whole handshake.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wstrb = WSTRB_RD;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len_words == '0) ? DONE : RD;
                end
            end
            RD: begin
                mem_valid = 1'b1;
                mem_addr  = src_q;
                if (expired) begin
                    state_d = ABORT;
                end else if (mem_ready) begin
                    state_d = WR;
                end
            end
            WR: begin
                mem_valid = 1'b1;
                mem_addr  = dst_q;
                mem_wstrb = WSTRB_WORD;
                if (expired) begin
                    state_d = ABORT;
                end else if (mem_ready) begin
                    state_d = (cnt_q == LEN_W'(1)) ? DONE : RD;
                end
            end
            ABORT: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job registers: addresses, remaining count, data buffer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                src_q <= src_addr & 32'hFFFF_FFFC;
                dst_q <= dst_addr & 32'hFFFF_FFFC;
                cnt_q <= len_words;
                err_q <= 1'b0;
            end
            if (expired) begin
                err_q <= 1'b1;
            end
            if (state_q == RD && mem_ready) begin
                wdata_q <= mem_rdata;
            end
            if (state_q == WR && mem_ready) begin
                src_q <= src_q + WORD_BYTES;
                dst_q <= dst_q + WORD_BYTES;
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

    assign err       = err_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mcu_subsys_dma_copy.sv
// Directed bench for the copy engine: zero-wait, wait-state, stall/timeout,
// address wrap, zero length and reset-mid-job scenarios.
module tb_mcu_subsys_dma_copy;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_words;
    logic        busy, done, err;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    mode    = 0;   // 0 zero-wait, 1 three wait states, 2 never ready
    int    wcnt    = 0;
    int    stab_err = 0;
    logic  prev_stall = 1'b0;
    logic [67:0] prev_bus = '0;
    txn_t  log_q[$];

    mcu_subsys_dma_copy #(
        .LEN_W   (16),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign mem_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? (wcnt == 3) : 1'b0);
    assign mem_rdata = pattern(mem_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_valid || mem_ready) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
        if (!rst && mem_valid && mem_ready)
            log_q.push_back('{addr: mem_addr, wstrb: mem_wstrb, wdata: mem_wdata});
    end

    always @(negedge clk) begin
        if (prev_stall && mem_valid && ({mem_addr, mem_wstrb, mem_wdata} != prev_bus))
            stab_err++;
        prev_stall = mem_valid && !mem_ready;
        prev_bus   = {mem_addr, mem_wstrb, mem_wdata};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a job at cycle 0 and observe `window` cycles at negedges.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                           input int window, output int done_at, output int dones,
                           output int busy_cyc, output int valid_cyc);
        int t0;
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
        t0 = cyc;
        log_q.delete();
        done_at = -1; dones = 0; busy_cyc = 0; valid_cyc = 0;
        for (int i = 0; i < window; i++) begin
            if (done) begin
                dones++;
                if (done_at < 0) done_at = cyc - t0;
            end
            if (busy) busy_cyc++;
            if (mem_valid) valid_cyc++;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int da, dn, bc, vc;
        logic [31:0] a;

        // Reset with start held high: reset must win.
        rst = 1'b1; start = 1'b1; src_addr = 32'h40; dst_addr = 32'h80; len_words = 16'd3;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_err",   {31'b0, err}, 32'd0);
        check("rst_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_start_busy", {31'b0, busy}, 32'd0);

        // Zero-wait copy of 4 words; done at 2N+1 = 9.
        mode = 0;
        run_job(32'h0000_0100, 32'h0001_0000, 16'd4, 20, da, dn, bc, vc);
        check("z4_ntxn", log_q.size(), 32'd8);
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_0100 + 32'(4 * i);
            check("z4_rd_addr",  log_q[2*i].addr, a);
            check("z4_rd_wstrb", {28'b0, log_q[2*i].wstrb}, 32'h0);
            check("z4_wr_addr",  log_q[2*i+1].addr, 32'h0001_0000 + 32'(4 * i));
            check("z4_wr_wstrb", {28'b0, log_q[2*i+1].wstrb}, 32'hF);
            check("z4_wr_data",  log_q[2*i+1].wdata, pattern(a));
        end
        check("z4_done_at", da, 32'd9);
        check("z4_dones",   dn, 32'd1);
        check("z4_busy",    bc, 32'd9);
        check("z4_err",     {31'b0, err}, 32'd0);

        // Zero length: no bus activity, done at cycle 1, busy for one cycle.
        run_job(32'h0000_0100, 32'h0001_0000, 16'd0, 8, da, dn, bc, vc);
        check("z0_valid",   vc, 32'd0);
        check("z0_done_at", da, 32'd1);
        check("z0_busy",    bc, 32'd1);
        check("z0_dones",   dn, 32'd1);

        // Three wait states per transfer, len 2: done at 17, request held stable.
        mode = 1; stab_err = 0;
        run_job(32'h0000_0302, 32'h0000_0401, 16'd2, 30, da, dn, bc, vc);
        check("w2_done_at", da, 32'd17);
        check("w2_stable",  stab_err, 32'd0);
        check("w2_ntxn",    log_q.size(), 32'd4);
        check("w2_rd0",     log_q[0].addr, 32'h0000_0300);
        check("w2_wr0",     log_q[1].addr, 32'h0000_0400);
        check("w2_wd0",     log_q[1].wdata, pattern(32'h0000_0300));
        check("w2_wr1",     log_q[3].addr, 32'h0000_0404);
        check("w2_wd1",     log_q[3].wdata, pattern(32'h0000_0304));

        // Responder never ready: 8 stalled cycles, abort, single done.
        mode = 2; stab_err = 0;
        run_job(32'h0000_0500, 32'h0000_0600, 16'd1, 25, da, dn, bc, vc);
        check("to_valid",   vc, 32'd8);
        check("to_done_at", da, 32'd10);
        check("to_dones",   dn, 32'd1);
        check("to_err",     {31'b0, err}, 32'd1);
        check("to_ntxn",    log_q.size(), 32'd0);
        check("to_stable",  stab_err, 32'd0);

        // Working responder again clears err.
        mode = 0;
        run_job(32'h0000_0500, 32'h0000_0600, 16'd1, 8, da, dn, bc, vc);
        check("rc_err",     {31'b0, err}, 32'd0);
        check("rc_done_at", da, 32'd3);

        // Address wrap.
        run_job(32'hFFFF_FFF8, 32'h0000_0200, 16'd3, 15, da, dn, bc, vc);
        check("wr_rd0", log_q[0].addr, 32'hFFFF_FFF8);
        check("wr_rd1", log_q[2].addr, 32'hFFFF_FFFC);
        check("wr_rd2", log_q[4].addr, 32'h0000_0000);
        check("wr_wd2", log_q[5].wdata, pattern(32'h0000_0000));
        check("wr_done_at", da, 32'd7);

        // Reset during a write of a 5-word job.
        @(negedge clk);
        src_addr = 32'h0000_0700; dst_addr = 32'h0000_0800; len_words = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_in_wr", {27'b0, mem_valid, mem_wstrb}, 32'h1F);
        rst = 1'b1;
        @(negedge clk);
        check("mr_valid", {31'b0, mem_valid}, 32'd0);
        check("mr_busy",  {31'b0, busy}, 32'd0);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy || mem_valid) dn++;
            @(negedge clk);
        end
        check("mr_quiet", dn, 32'd0);
        run_job(32'h0000_0900, 32'h0000_0A00, 16'd2, 10, da, dn, bc, vc);
        check("mr_new_done_at", da, 32'd5);
        check("mr_new_wd1", log_q[3].wdata, pattern(32'h0000_0904));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
